// File: rtl/mainfsm_pkg.sv
// rtl/mainfsm_pkg.sv - state encoding, datapath select codes and control word for mainfsm
// MAINFSM_ILLEGAL_TRAP_EN adds the UNKNOWN trap state.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
`ifdef MAINFSM_ILLEGAL_TRAP_EN
        , UNKNOWN = 4'd10
`endif
    } state_e;

    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP      = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] OP_BR      = 2'b10;
    localparam logic [1:0] OP_UNDEF   = 2'b11;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/mainfsm_if.sv
// rtl/mainfsm_if.sv - instruction-class inputs and control outputs of mainfsm
// MAINFSM_ILLEGAL_TRAP_EN adds the Illegal flag.
interface mainfsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
    logic       Illegal;

    modport master (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch, Illegal
    );
    modport slave (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch, Illegal
    );
`else
    modport master (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch
    );
    modport slave (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch
    );
`endif
endinterface

// File: rtl/flopr.sv
// rtl/flopr.sv - resettable register, synchronous active-high reset to zero
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end
endmodule

// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - Moore main control FSM of the multicycle ARM decoder
// MAINFSM_ILLEGAL_TRAP_EN: Op=11 traps in UNKNOWN and raises Illegal until reset.
module mainfsm
    import mainfsm_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    mainfsm_if.master bus
);
    state_e     state_q;
    state_e     state_d;
    logic [3:0] state_bits;
    ctrl_t      ctrl;
    logic       funct_unused;

    // FETCH encodes as zero, so the flop's clear-to-zero is the reset state.
    flopr #(.WIDTH(4)) u_state (
        .clk   (clk),
        .reset (reset),
        .d     (state_d),
        .q     (state_bits)
    );

    assign state_q      = state_e'(state_bits);
    assign funct_unused = ^bus.Funct[4:1];

    always_comb begin
        state_d = FETCH;
        ctrl    = '0;
        case (state_q)
            FETCH: begin
                state_d        = DECODE;
                ctrl.irwrite   = 1'b1;
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALU;
                ctrl.nextpc    = 1'b1;
            end
            DECODE: begin
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALU;
                case (bus.Op)
                    OP_DP:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
                    default: state_d = UNKNOWN;
`else
                    default: state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                state_d      = bus.Funct[0] ? MEMRD : MEMWR;
                ctrl.alusrca = SRCA_REG;
                ctrl.alusrcb = SRCB_IMM;
            end
            MEMRD: begin
                state_d     = MEMWB;
                ctrl.adrsrc = 1'b1;
            end
            MEMWB: begin
                ctrl.resultsrc = RES_DATA;
                ctrl.regw      = 1'b1;
            end
            MEMWR: begin
                ctrl.adrsrc = 1'b1;
                ctrl.memw   = 1'b1;
            end
            EXECUTER: begin
                state_d      = ALUWB;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = 1'b1;
            end
            EXECUTEI: begin
                state_d      = ALUWB;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = 1'b1;
            end
            ALUWB: begin
                ctrl.regw = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrcb   = SRCB_IMM;
                ctrl.resultsrc = RES_ALU;
                ctrl.branch    = 1'b1;
            end
`ifdef MAINFSM_ILLEGAL_TRAP_EN
            UNKNOWN: begin
                state_d = UNKNOWN;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign bus.IRWrite   = ctrl.irwrite;
    assign bus.AdrSrc    = ctrl.adrsrc;
    assign bus.ALUSrcA   = ctrl.alusrca;
    assign bus.ALUSrcB   = ctrl.alusrcb;
    assign bus.ResultSrc = ctrl.resultsrc;
    assign bus.ALUOp     = ctrl.aluop;
    assign bus.NextPC    = ctrl.nextpc;
    assign bus.RegW      = ctrl.regw;
    assign bus.MemW      = ctrl.memw;
    assign bus.Branch    = ctrl.branch;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
    assign bus.Illegal   = (state_q == UNKNOWN);
`endif

endmodule
